// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction sequencer for a small accumulator machine.
//   Steps IDLE -> FETCH -> DECODE -> EXEC -> FETCH ... until a HALT opcode or
//   a memory timeout parks it in HALT. Only clr leaves HALT.
// Ports:
//   clk       rising-edge clock
//   clr       asynchronous active-low reset
//   start     begin execution from IDLE
//   op        opcode field from the instruction register (latched in DECODE)
//   zero      accumulator X equals zero (used by JZ in EXEC)
//   mem_rdy   memory completes the current access this cycle
//   inst_en   {PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN}
//   mux_sum   00 pass Y, 01 X+Y, 10 X-Y, 11 address to PC
//   mux_y     drive X onto the memory write bus
//   r, we     memory read / write strobes
//   en_fetch  instruction-fetch cycle
//   busy      in FETCH, DECODE or EXEC
//   halted    in HALT
//   fault     sticky memory-timeout flag
//   icount    retired-instruction counter (wraps)
module seq_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             zero,
   input  logic             mem_rdy,
   output logic [5:0]       inst_en,
   output logic [1:0]       mux_sum,
   output logic             mux_y,
   output logic             r,
   output logic             we,
   output logic             en_fetch,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] icount
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_ADD   = 3'b001,
      OP_SUB   = 3'b010,
      OP_STORE = 3'b011,
      OP_JMP   = 3'b100,
      OP_JZ    = 3'b101,
      OP_NOP   = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   // Last tolerated wait cycle: the counter holds the number of earlier
   // consecutive wait cycles, so the WAIT_MAX-th one sees WAIT_MAX-1.
   localparam logic [WC_W-1:0] WLAST = WC_W'(WAIT_MAX - 1);

   state_t          state;
   logic [2:0]      op_q;
   logic [WC_W-1:0] wcnt;
   logic            pending;
   logic            timeout;

   // Memory-bound states: FETCH and the four memory opcodes (op_q[2]==0).
   assign pending = (state == FETCH) || (state == EXEC && !op_q[2]);
   // A ready strobe in the final wait cycle wins over the timeout.
   assign timeout = pending && !mem_rdy && (wcnt == WLAST);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         op_q   <= 3'b000;
         wcnt   <= '0;
         icount <= '0;
         fault  <= 1'b0;
      end else begin
         // Counter only survives while the same access is still outstanding.
         if (pending && !mem_rdy && !timeout) wcnt <= wcnt + WC_W'(1);
         else                                 wcnt <= '0;

         case (state)
            IDLE:   if (start) state <= FETCH;
            FETCH: begin
               if (mem_rdy)      state <= DECODE;
               else if (timeout) begin
                  state <= HALT;
                  fault <= 1'b1;
               end
            end
            DECODE: begin
               op_q  <= op;
               state <= EXEC;
            end
            EXEC: begin
               case (op_q)
                  OP_LOAD, OP_ADD, OP_SUB, OP_STORE: begin
                     if (mem_rdy) begin
                        state  <= FETCH;
                        icount <= icount + CNT_W'(1);
                     end else if (timeout) begin
                        state <= HALT;
                        fault <= 1'b1;
                     end
                  end
                  OP_JMP, OP_JZ, OP_NOP: begin
                     state  <= FETCH;
                     icount <= icount + CNT_W'(1);
                  end
                  default: state <= HALT;
               endcase
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      inst_en  = 6'b000000;
      mux_sum  = 2'b00;
      mux_y    = 1'b0;
      r        = 1'b0;
      we       = 1'b0;
      en_fetch = 1'b0;
      busy     = 1'b0;
      halted   = 1'b0;
      case (state)
         FETCH: begin
            busy     = 1'b1;
            r        = 1'b1;
            en_fetch = 1'b1;
            if (mem_rdy) inst_en = 6'b110010;
         end
         DECODE: begin
            busy    = 1'b1;
            inst_en = 6'b001000;
         end
         EXEC: begin
            busy = 1'b1;
            case (op_q)
               OP_LOAD, OP_ADD, OP_SUB: begin
                  r       = 1'b1;
                  mux_sum = op_q[1:0];
                  if (mem_rdy) inst_en = 6'b000101;
               end
               OP_STORE: begin
                  we    = 1'b1;
                  mux_y = 1'b1;
               end
               OP_JMP: begin
                  mux_sum = 2'b11;
                  inst_en = 6'b100000;
               end
               OP_JZ: begin
                  if (zero) begin
                     mux_sum = 2'b11;
                     inst_en = 6'b100000;
                  end
               end
               default: ;
            endcase
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

endmodule
